// File: rtl/somatorio_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : somatorio_ctrl
// Description : Summation sequencer. It loads a down-counter with N and
//               accumulates N+(N-1)+...+1. It mirrors set/dec strobes for
//               external trackers. Optional macro: SOMATORIO_SAT_EN, which
//               makes the accumulator saturate and adds a sticky ovf flag.
// Revision    : 1.0 - initial release
// ============================================================================
module somatorio_ctrl #(
    parameter int WIDTH     = 4,
    parameter int SUM_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [WIDTH-1:0]     n_in,
    output logic                 busy,
    output logic                 done,
    output logic [SUM_WIDTH-1:0] sum,
    output logic                 cnt_set,
    output logic                 cnt_dec,
    output logic                 nill,
    output logic                 ovf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     cnt_q, cnt_d;
    logic [SUM_WIDTH-1:0] sum_q, sum_d;
    logic                 done_q, done_d;
    logic                 cnt_set_q, cnt_set_d;
    logic                 cnt_dec_q, cnt_dec_d;

`ifdef SOMATORIO_SAT_EN
    logic                 ovf_q, ovf_d;
    // One extra bit exposes the carry that signals a saturating add.
    logic [SUM_WIDTH:0]   w_sum_ext;
    assign w_sum_ext = {1'b0, sum_q} + (SUM_WIDTH+1)'(cnt_q);
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        done_d    = 1'b0;
        cnt_set_d = 1'b0;
        cnt_dec_d = 1'b0;
`ifdef SOMATORIO_SAT_EN
        ovf_d     = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_RUN;
                    cnt_d     = n_in;
                    sum_d     = '0;
                    cnt_set_d = 1'b1;
`ifdef SOMATORIO_SAT_EN
                    ovf_d     = 1'b0;
`endif
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    sum_d   = '0;
`ifdef SOMATORIO_SAT_EN
                    ovf_d   = 1'b0;
`endif
                end else if (cnt_q != '0) begin
                    cnt_d     = cnt_q - 1'b1;
                    cnt_dec_d = 1'b1;
`ifdef SOMATORIO_SAT_EN
                    if (w_sum_ext[SUM_WIDTH]) begin
                        sum_d = '1;
                        ovf_d = 1'b1;
                    end else begin
                        sum_d = w_sum_ext[SUM_WIDTH-1:0];
                    end
`else
                    sum_d     = sum_q + SUM_WIDTH'(cnt_q);
`endif
                end else begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            sum_q     <= '0;
            done_q    <= 1'b0;
            cnt_set_q <= 1'b0;
            cnt_dec_q <= 1'b0;
`ifdef SOMATORIO_SAT_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sum_q     <= sum_d;
            done_q    <= done_d;
            cnt_set_q <= cnt_set_d;
            cnt_dec_q <= cnt_dec_d;
`ifdef SOMATORIO_SAT_EN
            ovf_q     <= ovf_d;
`endif
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign sum     = sum_q;
    assign cnt_set = cnt_set_q;
    assign cnt_dec = cnt_dec_q;
    assign nill    = (cnt_q == '0);
`ifdef SOMATORIO_SAT_EN
    assign ovf     = ovf_q;
`else
    assign ovf     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_somatorio_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_somatorio_ctrl
// Description : Directed bench for somatorio_ctrl (8-bit and 6-bit sum builds).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_somatorio_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic [3:0] n_in;

    logic       busy, done, cnt_set, cnt_dec, nill, ovf;
    logic [7:0] sum;
    logic       busy6, done6, cnt_set6, cnt_dec6, nill6, ovf6;
    logic [5:0] sum6;

    int n_chk;
    int n_bad;

    somatorio_ctrl #(.WIDTH(4), .SUM_WIDTH(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .n_in(n_in),
        .busy(busy), .done(done), .sum(sum), .cnt_set(cnt_set),
        .cnt_dec(cnt_dec), .nill(nill), .ovf(ovf)
    );

    somatorio_ctrl #(.WIDTH(4), .SUM_WIDTH(6)) u_dut6 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .n_in(n_in),
        .busy(busy6), .done(done6), .sum(sum6), .cnt_set(cnt_set6),
        .cnt_dec(cnt_dec6), .nill(nill6), .ovf(ovf6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch a run, optionally holding start throughout, and check the
    // strobe count, latency and result.
    task automatic run(input logic [3:0] n, input logic hold, input logic abrt,
                       input logic [7:0] exp_sum);
        int cycles;
        int decs;
        start = 1'b1;
        abort = abrt;
        n_in  = n;
        tick();
        start = hold;
        abort = 1'b0;
        chk("cnt_set", {31'd0, cnt_set}, 32'd1);
        chk("busy_run", {31'd0, busy}, 32'd1);
        cycles = 0;
        decs   = 0;
        while (!done && cycles < 40) begin
            if (cnt_dec) decs++;
            tick();
            cycles++;
        end
        start = 1'b0;
        chk("latency", cycles, 32'(n) + 32'd1);
        chk("dec_count", decs, 32'(n));
        chk("sum", {24'd0, sum}, {24'd0, exp_sum});
        chk("nill_done", {31'd0, nill}, 32'd1);
        tick();
        chk("busy_after", {31'd0, busy}, 32'd0);
        chk("done_pulse", {31'd0, done}, 32'd0);
        chk("sum_held", {24'd0, sum}, {24'd0, exp_sum});
    endtask

    initial begin
        n_chk = 0;
        n_bad = 0;
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        n_in  = 4'd0;
        #2;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_sum", {24'd0, sum}, 32'd0);
        chk("rst_nill", {31'd0, nill}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Basic runs
        run(4'd5, 1'b0, 1'b0, 8'd15);
        run(4'd0, 1'b0, 1'b0, 8'd0);
        run(4'd15, 1'b0, 1'b0, 8'd120);
        chk("ovf_120", {31'd0, ovf}, 32'd0);

        // Start held every cycle: single run only
        run(4'd5, 1'b1, 1'b0, 8'd15);

        // Start and abort together in IDLE: start wins
        run(4'd1, 1'b0, 1'b1, 8'd1);

        // Abort in IDLE has no effect
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_idle_sum", {24'd0, sum}, 32'd1);

        // Abort mid-run when cnt=3
        start = 1'b1;
        n_in  = 4'd6;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("partial_sum", {24'd0, sum}, 32'd15);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_sum", {24'd0, sum}, 32'd0);
        chk("abort_nill", {31'd0, nill}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk("abort_nodone", {31'd0, done}, 32'd0);
            tick();
        end

        // Async reset mid-run (n=9, cnt=4 after five decrements)
        start = 1'b1;
        n_in  = 4'd9;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("pre_rst_dec", {31'd0, cnt_dec}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_sum", {24'd0, sum}, 32'd0);
        chk("arst_dec", {31'd0, cnt_dec}, 32'd0);
        chk("arst_nill", {31'd0, nill}, 32'd1);
        chk("arst_done", {31'd0, done}, 32'd0);
        tick();
        #3;
        rst = 1'b0;
        tick();
        run(4'd2, 1'b0, 1'b0, 8'd3);

        // Narrow accumulator, n=15
        start = 1'b1;
        n_in  = 4'd15;
        tick();
        start = 1'b0;
        for (int i = 0; i < 40 && !done6; i++) tick();
        chk("w6_done", {31'd0, done6}, 32'd1);
`ifdef SOMATORIO_SAT_EN
        chk("w6_sum", {26'd0, sum6}, 32'd63);
        chk("w6_ovf", {31'd0, ovf6}, 32'd1);
`else
        chk("w6_sum", {26'd0, sum6}, 32'd56);
        chk("w6_ovf", {31'd0, ovf6}, 32'd0);
`endif
        chk("w8_sum", {24'd0, sum}, 32'd120);
        tick();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
